// File: rtl/mdio_pkg.sv
// Shared MDIO responder types: FSM states, opcodes, register indices and reset values.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_PRE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_RDATA,
        S_WDATA
    } mdio_state_e;

    localparam logic [1:0]  OP_READ   = 2'b10;
    localparam logic [1:0]  OP_WRITE  = 2'b01;

    localparam logic [4:0]  REG_CTRL  = 5'd0;
    localparam logic [4:0]  REG_STAT  = 5'd1;
    localparam logic [4:0]  REG_ID1   = 5'd2;
    localparam logic [4:0]  REG_ID2   = 5'd3;
    localparam logic [4:0]  REG_ANAR  = 5'd4;
    localparam logic [4:0]  REG_USR5  = 5'd5;
    localparam logic [4:0]  REG_USR6  = 5'd6;
    localparam logic [4:0]  REG_USR7  = 5'd7;

    localparam logic [15:0] DEF_CTRL  = 16'h3100;
    localparam logic [15:0] DEF_ANAR  = 16'h01E1;
    localparam logic [15:0] DEF_USR   = 16'h0000;
    localparam logic [15:0] STAT_BASE = 16'h7809;

    // Preamble length in bits; the counter saturates here.
    localparam logic [5:0]  PRE_LEN   = 6'd32;
    // Number of read data bits driven before the line is released.
    localparam logic [4:0]  DATA_BITS = 5'd16;

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO line bundle between station/line model (master) and PHY responder (slave).
// Latency: n/a (wires only).
// Backpressure: none; the station paces every bit with mdc.
interface mdio_phy_responder_if;
    logic mdc;
    logic mdio_i;
    logic mdio_o;
    logic mdio_t;

    modport master (output mdc, output mdio_i, input mdio_o, input mdio_t);
    modport slave  (input mdc, input mdio_i, output mdio_o, output mdio_t);
endinterface

// File: rtl/mdio_edge_sync.sv
// Brings mdc/mdio into the aclk domain and strobes mdc rising/falling edges.
// Latency: 2 aclk to synchronized value, strobe on the 3rd aclk after an mdc edge.
// Backpressure: none; strobes are single-cycle pulses.
module mdio_edge_sync (
    input  logic aclk,
    input  logic areset,
    input  logic i_mdc,
    input  logic i_mdio,
    output logic o_mdc_rise,
    output logic o_mdc_fall,
    output logic o_mdio
);
    logic [1:0] r_mdc_sync;
    logic [1:0] r_mdio_sync;
    logic       r_mdc_prev;

    // Matched 2-flop chains keep mdio aligned with mdc; prev flop feeds edge detect.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_mdc_sync  <= 2'b00;
            r_mdio_sync <= 2'b00;
            r_mdc_prev  <= 1'b0;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[0], i_mdc};
            r_mdio_sync <= {r_mdio_sync[0], i_mdio};
            r_mdc_prev  <= r_mdc_sync[1];
        end
    end

    assign o_mdc_rise = r_mdc_sync[1] & ~r_mdc_prev;
    assign o_mdc_fall = ~r_mdc_sync[1] & r_mdc_prev;
    assign o_mdio     = r_mdio_sync[1];
endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder: frame FSM plus a small management register file.
// Latency: read data driven on the synchronized mdc fall (~3 aclk after mdc falls); writes commit on the 16th data sample.
// Backpressure: none; the station owns timing, a static mdc simply freezes the FSM.
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] PHY_ID1  = 16'h0022,
    parameter logic [15:0] PHY_ID2  = 16'h1560
) (
    input  logic                  aclk,
    input  logic                  areset,
    mdio_phy_responder_if.slave   mdio_bus,
    input  logic                  link_up,
    output logic [15:0]           ctrl_reg
);
    logic        w_rise, w_fall, w_bit;

    mdio_state_e r_state,   w_state_nxt;
    logic [5:0]  r_pre_cnt, w_pre_cnt_nxt;
    logic [4:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [14:0] r_shift,   w_shift_nxt;
    logic        r_is_read, w_is_read_nxt;
    logic        r_match,   w_match_nxt;
    logic [4:0]  r_regad,   w_regad_nxt;
    logic [15:0] r_rdata,   w_rdata_nxt;
    logic        r_mdio_o,  w_mdio_o_nxt;
    logic        r_mdio_t,  w_mdio_t_nxt;
    logic [15:0] w_shift_in;
    logic [15:0] w_rd_mux;
    logic        w_commit;
    logic [15:0] w_wdata;

    logic [15:0] r_reg0, r_reg4, r_reg5, r_reg6, r_reg7;

    mdio_edge_sync u_sync (
        .aclk       (aclk),
        .areset     (areset),
        .i_mdc      (mdio_bus.mdc),
        .i_mdio     (mdio_bus.mdio_i),
        .o_mdc_rise (w_rise),
        .o_mdc_fall (w_fall),
        .o_mdio     (w_bit)
    );

    // Incoming bit appended to the running shift; low bits give the field just completed.
    assign w_shift_in = {r_shift, w_bit};

    // Read mux addressed by the REGAD value completing on this sample.
    always_comb begin
        w_rd_mux = 16'h0000;
        case (w_shift_in[4:0])
            REG_CTRL: w_rd_mux = r_reg0;
            REG_STAT: w_rd_mux = STAT_BASE | {13'd0, link_up, 2'b00};
            REG_ID1:  w_rd_mux = PHY_ID1;
            REG_ID2:  w_rd_mux = PHY_ID2;
            REG_ANAR: w_rd_mux = r_reg4;
            REG_USR5: w_rd_mux = r_reg5;
            REG_USR6: w_rd_mux = r_reg6;
            REG_USR7: w_rd_mux = r_reg7;
            default:  w_rd_mux = 16'h0000;
        endcase
    end

    // FSM and datapath state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= S_PRE;
            r_pre_cnt <= 6'd0;
            r_bit_cnt <= 5'd0;
            r_shift   <= 15'd0;
            r_is_read <= 1'b0;
            r_match   <= 1'b0;
            r_regad   <= 5'd0;
            r_rdata   <= 16'h0000;
            r_mdio_o  <= 1'b0;
            r_mdio_t  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_pre_cnt <= w_pre_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_is_read <= w_is_read_nxt;
            r_match   <= w_match_nxt;
            r_regad   <= w_regad_nxt;
            r_rdata   <= w_rdata_nxt;
            r_mdio_o  <= w_mdio_o_nxt;
            r_mdio_t  <= w_mdio_t_nxt;
        end
    end

    // Frame decode: sample on mdc rise, change the drive only on mdc fall.
    always_comb begin
        w_state_nxt   = r_state;
        w_pre_cnt_nxt = r_pre_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_is_read_nxt = r_is_read;
        w_match_nxt   = r_match;
        w_regad_nxt   = r_regad;
        w_rdata_nxt   = r_rdata;
        w_mdio_o_nxt  = r_mdio_o;
        w_mdio_t_nxt  = r_mdio_t;
        w_commit      = 1'b0;
        w_wdata       = w_shift_in;
        case (r_state)
            S_PRE: if (w_rise) begin
                if (w_bit) begin
                    if (r_pre_cnt != PRE_LEN) w_pre_cnt_nxt = r_pre_cnt + 6'd1;
                end else begin
                    // The 0 that ends a full preamble is also the first start bit.
                    if (r_pre_cnt == PRE_LEN) w_state_nxt = S_ST;
                    w_pre_cnt_nxt = 6'd0;
                end
            end
            S_ST: if (w_rise) begin
                w_bit_cnt_nxt = 5'd0;
                w_state_nxt   = w_bit ? S_OP : S_PRE;
            end
            S_OP: if (w_rise) begin
                w_shift_nxt   = w_shift_in[14:0];
                w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                if (r_bit_cnt == 5'd1) begin
                    w_bit_cnt_nxt = 5'd0;
                    if (w_shift_in[1:0] == OP_READ) begin
                        w_is_read_nxt = 1'b1;
                        w_state_nxt   = S_PHYAD;
                    end else if (w_shift_in[1:0] == OP_WRITE) begin
                        w_is_read_nxt = 1'b0;
                        w_state_nxt   = S_PHYAD;
                    end else begin
                        w_state_nxt   = S_PRE;
                    end
                end
            end
            S_PHYAD: if (w_rise) begin
                w_shift_nxt   = w_shift_in[14:0];
                w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                if (r_bit_cnt == 5'd4) begin
                    w_bit_cnt_nxt = 5'd0;
                    w_match_nxt   = (w_shift_in[4:0] == PHY_ADDR);
                    w_state_nxt   = S_REGAD;
                end
            end
            S_REGAD: if (w_rise) begin
                w_shift_nxt   = w_shift_in[14:0];
                w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                if (r_bit_cnt == 5'd4) begin
                    w_bit_cnt_nxt = 5'd0;
                    w_regad_nxt   = w_shift_in[4:0];
                    w_rdata_nxt   = w_rd_mux;
                    w_state_nxt   = S_TA;
                end
            end
            S_TA: begin
                if (w_rise) begin
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd1) begin
                        w_bit_cnt_nxt = 5'd0;
                        w_state_nxt   = r_is_read ? S_RDATA : S_WDATA;
                    end
                end else if (w_fall && r_bit_cnt == 5'd1 && r_is_read && r_match) begin
                    // Second turnaround bit: PHY takes the line and drives 0.
                    w_mdio_o_nxt = 1'b0;
                    w_mdio_t_nxt = 1'b0;
                end
            end
            S_RDATA: if (w_fall) begin
                if (r_bit_cnt == DATA_BITS) begin
                    w_mdio_o_nxt  = 1'b0;
                    w_mdio_t_nxt  = 1'b1;
                    w_bit_cnt_nxt = 5'd0;
                    w_pre_cnt_nxt = 6'd0;
                    w_state_nxt   = S_PRE;
                end else begin
                    if (r_match) begin
                        w_mdio_o_nxt = r_rdata[15];
                        w_mdio_t_nxt = 1'b0;
                    end
                    w_rdata_nxt   = r_rdata << 1;
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                end
            end
            S_WDATA: if (w_rise) begin
                w_shift_nxt   = w_shift_in[14:0];
                w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                if (r_bit_cnt == 5'd15) begin
                    w_commit      = r_match;
                    w_bit_cnt_nxt = 5'd0;
                    w_pre_cnt_nxt = 6'd0;
                    w_state_nxt   = S_PRE;
                end
            end
            default: begin
                w_state_nxt   = S_PRE;
                w_pre_cnt_nxt = 6'd0;
            end
        endcase
    end

    // Register file: RW registers take writes; RO and unmapped writes fall through.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_reg0 <= DEF_CTRL;
            r_reg4 <= DEF_ANAR;
            r_reg5 <= DEF_USR;
            r_reg6 <= DEF_USR;
            r_reg7 <= DEF_USR;
        end else if (w_commit) begin
            case (r_regad)
                REG_CTRL: begin
                    if (w_wdata[15]) begin
                        // Soft reset is self-clearing: bit 15 never reads back as 1.
                        r_reg0 <= DEF_CTRL;
                        r_reg4 <= DEF_ANAR;
                        r_reg5 <= DEF_USR;
                        r_reg6 <= DEF_USR;
                        r_reg7 <= DEF_USR;
                    end else begin
                        r_reg0 <= {1'b0, w_wdata[14:0]};
                    end
                end
                REG_ANAR: r_reg4 <= w_wdata;
                REG_USR5: r_reg5 <= w_wdata;
                REG_USR6: r_reg6 <= w_wdata;
                REG_USR7: r_reg7 <= w_wdata;
                default:  ;
            endcase
        end
    end

    assign mdio_bus.mdio_o = r_mdio_o;
    assign mdio_bus.mdio_t = r_mdio_t;
    assign ctrl_reg        = r_reg0;
endmodule
